// File: rtl/player_pkg.sv
// Shared definitions for the player sprite position path.
// Holds the motion state encoding, the sprite/play-area defaults and the
// field slices of the packed {y, x} position word. The drawing stage
// imports the same slices, so both ends agree on the word layout.
package player_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_JUMP   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    localparam int SPRITE     = 64;
    localparam int AREA_W_DEF = 384;
    localparam int AREA_H_DEF = 960;

    // Packed position word: {y[19:10], x[9:0]}
    localparam int Y_MSB = 19;
    localparam int Y_LSB = 10;
    localparam int X_MSB = 9;
    localparam int X_LSB = 0;

endpackage

// File: rtl/player_ctl_rise_detect.sv
// Registered rising-edge detector.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (clears the history bit)
//   d     - level input, already synchronous to clk
//   rise  - high for the cycle where d is high and was low last cycle
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/player_ctl.sv
// Per-frame position controller for the player sprite.
// Converts left/right/jump button levels into a packed position word that
// changes only on the first cycle of vertical blanking, so it is stable for
// the whole visible frame.
// Ports:
//   i_pclk     - pixel clock
//   i_rst      - asynchronous active-low reset
//   i_vblnk    - vertical blank level from the timing chain
//   i_left     - move-left level (synchronous)
//   i_right    - move-right level (synchronous)
//   i_jump     - jump level (synchronous)
//   o_data     - {y[19:10], x[9:0]} in play-area coordinates, registered
//   o_airborne - high while jumping or falling, registered
module player_ctl #(
    parameter int AREA_W   = player_pkg::AREA_W_DEF,
    parameter int AREA_H   = player_pkg::AREA_H_DEF,
    parameter int SPRITE   = player_pkg::SPRITE,
    parameter int INIT_X   = 160,
    parameter int SPEED    = 4,
    parameter int JUMP_V   = 20,
    parameter int MAX_FALL = 16
) (
    input  logic        i_pclk,
    input  logic        i_rst,
    input  logic        i_vblnk,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_jump,
    output logic [19:0] o_data,
    output logic        o_airborne
);

    import player_pkg::*;

    localparam logic signed [10:0] X_MAX_S   = 11'(AREA_W - SPRITE);
    localparam logic signed [10:0] SPEED_S   = 11'(SPEED);
    localparam logic [9:0]         X_MAX     = 10'(AREA_W - SPRITE);
    localparam logic [9:0]         X_INIT    = 10'(INIT_X);
    localparam logic [9:0]         FLOOR_Y   = 10'(AREA_H - SPRITE);
    localparam logic [10:0]        FLOOR_Y11 = 11'(AREA_H - SPRITE);
    localparam logic [9:0]         TAKEOFF_Y = 10'(AREA_H - SPRITE - JUMP_V);
    localparam logic [4:0]         TAKEOFF_V = 5'(JUMP_V - 1);
    localparam logic [5:0]         MAX_FALL6 = 6'(MAX_FALL);

    logic       tick;
    logic       jump_rise;
    logic       jump_pend;
    logic       jump_go;
    logic [9:0] x_q, x_n;
    logic [9:0] y_q, y_n;
    logic [4:0] vel_q, vel_n;
    state_t     state_q, state_n;
    logic       airborne_q;

    logic signed [10:0] x_left, x_right;
    logic [4:0]         vel_dec;
    logic [5:0]         vel_inc;
    logic [4:0]         vel_fall;
    logic [10:0]        y_fall;

    rise_detect u_vblnk_rise (
        .clk   (i_pclk),
        .rst_n (i_rst),
        .d     (i_vblnk),
        .rise  (tick)
    );

    rise_detect u_jump_rise (
        .clk   (i_pclk),
        .rst_n (i_rst),
        .d     (i_jump),
        .rise  (jump_rise)
    );

    // A press arriving on the tick cycle itself still counts for that tick.
    assign jump_go = jump_pend | jump_rise;

    always_comb begin
        x_left   = $signed({1'b0, x_q}) - SPEED_S;
        x_right  = $signed({1'b0, x_q}) + SPEED_S;
        vel_dec  = vel_q - 5'd1;
        vel_inc  = {1'b0, vel_q} + 6'd1;
        vel_fall = (vel_inc > MAX_FALL6) ? MAX_FALL6[4:0] : vel_inc[4:0];
        // 11 bits so a landing overshoot is visible before the floor clamp
        y_fall   = {1'b0, y_q} + {6'd0, vel_fall};
    end

    always_comb begin
        x_n     = x_q;
        y_n     = y_q;
        vel_n   = vel_q;
        state_n = state_q;

        if (i_left && !i_right) begin
            x_n = (x_left < 11'sd0) ? 10'd0 : x_left[9:0];
        end else if (i_right && !i_left) begin
            x_n = (x_right > X_MAX_S) ? X_MAX : x_right[9:0];
        end

        case (state_q)
            ST_GROUND: begin
                if (jump_go) begin
                    y_n     = TAKEOFF_Y;
                    vel_n   = TAKEOFF_V;
                    state_n = ST_JUMP;
                end
            end
            ST_JUMP: begin
                if (y_q < {5'd0, vel_q}) begin
                    // would pass the top edge: pin to the ceiling and drop
                    y_n     = 10'd0;
                    vel_n   = 5'd0;
                    state_n = ST_FALL;
                end else begin
                    y_n   = y_q - {5'd0, vel_q};
                    vel_n = vel_dec;
                    if (vel_dec == 5'd0) begin
                        state_n = ST_FALL;
                    end
                end
            end
            ST_FALL: begin
                if (y_fall >= FLOOR_Y11) begin
                    y_n     = FLOOR_Y;
                    vel_n   = 5'd0;
                    state_n = ST_GROUND;
                end else begin
                    y_n   = y_fall[9:0];
                    vel_n = vel_fall;
                end
            end
            default: begin
                y_n     = FLOOR_Y;
                vel_n   = 5'd0;
                state_n = ST_GROUND;
            end
        endcase
    end

    always_ff @(posedge i_pclk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_GROUND;
        end else if (tick) begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst) begin
        if (!i_rst) begin
            x_q        <= X_INIT;
            y_q        <= FLOOR_Y;
            vel_q      <= 5'd0;
            airborne_q <= 1'b0;
            jump_pend  <= 1'b0;
        end else begin
            if (tick) begin
                x_q        <= x_n;
                y_q        <= y_n;
                vel_q      <= vel_n;
                airborne_q <= (state_n != ST_GROUND);
                // every tick drops the request, used or not
                jump_pend  <= 1'b0;
            end else if (jump_rise) begin
                jump_pend <= 1'b1;
            end
        end
    end

    assign o_data     = {y_q, x_q};
    assign o_airborne = airborne_q;

endmodule

// File: tb/tb_player_ctl.sv
module tb_player_ctl;

    logic        clk;
    logic        rst;
    logic        vblnk;
    logic        left;
    logic        right;
    logic        jump;
    logic [19:0] data;
    logic        airborne;

    int checks = 0;
    int errors = 0;

    player_ctl dut (
        .i_pclk     (clk),
        .i_rst      (rst),
        .i_vblnk    (vblnk),
        .i_left     (left),
        .i_right    (right),
        .i_jump     (jump),
        .o_data     (data),
        .o_airborne (airborne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame: vblank rises before a posedge, then falls. Returns at a negedge.
    task automatic frame();
        @(negedge clk) vblnk = 1'b1;
        @(negedge clk) vblnk = 1'b0;
    endtask

    task automatic pulse_jump();
        @(negedge clk) jump = 1'b1;
        @(negedge clk) jump = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vblnk = 1'($urandom_range(0, 1));
            left  = 1'($urandom_range(0, 1));
            right = 1'($urandom_range(0, 1));
            jump  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (data !== 20'hE00A0 || airborne !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: data=%h air=%b expected data=e00a0 air=0", data, airborne);
            end
        end
        @(negedge clk);
        vblnk = 0; left = 0; right = 0; jump = 0;
        @(negedge clk) rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: data=%h air=%b expected data=e00a0 air=0", data, airborne);
        end
    endtask

    task automatic test_walk();
        int exp_x [3] = '{164, 168, 172};
        right = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame();
            checks++;
            if (data !== {10'd896, 10'(exp_x[i])} || airborne !== 1'b0) begin
                errors++;
                $display("FAIL walk_right[%0d]: data=%h expected %h", i, data, {10'd896, 10'(exp_x[i])});
            end
        end
        repeat (37) frame();
        checks++;
        if (data[9:0] !== 10'd320) begin
            errors++;
            $display("FAIL walk_reach_right: x=%0d expected 320", data[9:0]);
        end
        frame();
        checks++;
        if (data[9:0] !== 10'd320) begin
            errors++;
            $display("FAIL clamp_right: x=%0d expected 320", data[9:0]);
        end
        left = 1'b1;
        frame();
        checks++;
        if (data[9:0] !== 10'd320) begin
            errors++;
            $display("FAIL both_held: x=%0d expected 320", data[9:0]);
        end
        right = 1'b0;
        repeat (80) frame();
        checks++;
        if (data[9:0] !== 10'd0) begin
            errors++;
            $display("FAIL walk_reach_left: x=%0d expected 0", data[9:0]);
        end
        frame();
        checks++;
        if (data[9:0] !== 10'd0 || data[19:10] !== 10'd896) begin
            errors++;
            $display("FAIL clamp_left: data=%h expected %h", data, {10'd896, 10'd0});
        end
        left = 1'b0; right = 1'b1;
        repeat (40) frame();
        right = 1'b0;
        // no ticks: outputs hold
        repeat (5) @(negedge clk);
        checks++;
        if (data !== 20'hE00A0) begin
            errors++;
            $display("FAIL hold_between_ticks: data=%h expected e00a0", data);
        end
    endtask

    task automatic test_jump_arc();
        int exp_y [3] = '{876, 857, 839};
        pulse_jump();
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL jump_waits_tick: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
        for (int i = 0; i < 3; i++) begin
            frame();
            checks++;
            if (data !== {10'(exp_y[i]), 10'd160} || airborne !== 1'b1) begin
                errors++;
                $display("FAIL jump_rise[%0d]: data=%h air=%b expected %h air=1", i, data, airborne, {10'(exp_y[i]), 10'd160});
            end
        end
        repeat (17) frame();
        checks++;
        if (data[19:10] !== 10'd686 || airborne !== 1'b1) begin
            errors++;
            $display("FAIL jump_apex: y=%0d air=%b expected 686 air=1", data[19:10], airborne);
        end
        frame();
        checks++;
        if (data[19:10] !== 10'd687) begin
            errors++;
            $display("FAIL fall_start: y=%0d expected 687", data[19:10]);
        end
        repeat (15) frame();
        checks++;
        if (data[19:10] !== 10'd822) begin
            errors++;
            $display("FAIL fall_terminal: y=%0d expected 822", data[19:10]);
        end
        frame();
        checks++;
        if (data[19:10] !== 10'd838) begin
            errors++;
            $display("FAIL fall_capped: y=%0d expected 838", data[19:10]);
        end
        repeat (3) frame();
        checks++;
        if (data[19:10] !== 10'd886 || airborne !== 1'b1) begin
            errors++;
            $display("FAIL pre_land: y=%0d air=%b expected 886 air=1", data[19:10], airborne);
        end
        frame();
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL land_clamp: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
        frame();
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL stay_ground: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
    endtask

    task automatic test_same_cycle_press();
        @(negedge clk) begin vblnk = 1'b1; jump = 1'b1; end
        @(negedge clk) begin vblnk = 1'b0; jump = 1'b0; end
        checks++;
        if (data[19:10] !== 10'd876 || airborne !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_press: y=%0d air=%b expected 876 air=1", data[19:10], airborne);
        end
        repeat (40) frame();
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_land: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
    endtask

    task automatic test_held_jump();
        @(negedge clk) jump = 1'b1;
        repeat (41) frame();
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL held_land: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
        repeat (3) frame();
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL held_no_retrigger: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
        @(negedge clk) jump = 1'b0;
    endtask

    task automatic test_airborne_press();
        pulse_jump();
        repeat (20) frame();
        pulse_jump();
        frame();
        checks++;
        if (data[19:10] !== 10'd687 || airborne !== 1'b1) begin
            errors++;
            $display("FAIL fall_press_ignored: y=%0d air=%b expected 687 air=1", data[19:10], airborne);
        end
        repeat (19) frame();
        pulse_jump();
        frame();
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL land_with_press: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
        frame();
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL press_not_kept: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
    endtask

    task automatic test_reset_mid_jump();
        pulse_jump();
        right = 1'b1;
        repeat (5) frame();
        right = 1'b0;
        checks++;
        if (data !== {10'd806, 10'd180} || airborne !== 1'b1) begin
            errors++;
            $display("FAIL mid_jump_pos: data=%h air=%b expected %h air=1", data, airborne, {10'd806, 10'd180});
        end
        // jump pending request queued just before reset
        @(negedge clk) jump = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
        @(negedge clk) jump = 1'b0;
        @(negedge clk) rst = 1'b1;
        frame();
        checks++;
        if (data !== 20'hE00A0 || airborne !== 1'b0) begin
            errors++;
            $display("FAIL no_pend_after_reset: data=%h air=%b expected e00a0 air=0", data, airborne);
        end
    endtask

    initial begin
        rst = 1'b0; vblnk = 0; left = 0; right = 0; jump = 0;
        test_reset();
        test_walk();
        test_jump_arc();
        test_same_cycle_press();
        test_held_jump();
        test_airborne_press();
        test_reset_mid_jump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
